// File: rtl/memory_ram_if.sv
// Request/response bundle for memory_ram: request fields driven by the master,
// load data and the ready/done/error status driven back by the RAM (slave).
// Latency: none, wires only. Backpressure: master may only launch while ready_out=1.
interface memory_ram_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_in;
    logic                 we_in;
    logic [1:0]           size_in;
    logic                 sign_in;
    logic [BIT_WIDTH-1:0] Address_in;
    logic [BIT_WIDTH-1:0] Write_Data_in;
    logic [BIT_WIDTH-1:0] Read_Data_out;
    logic                 ready_out;
    logic                 done_out;
    logic                 error_out;

    modport master (
        output req_in, we_in, size_in, sign_in, Address_in, Write_Data_in,
        input  Read_Data_out, ready_out, done_out, error_out
    );

    modport slave (
        input  req_in, we_in, size_in, sign_in, Address_in, Write_Data_in,
        output Read_Data_out, ready_out, done_out, error_out
    );
endinterface

// File: rtl/memory_ram.sv
// Byte-addressed little-endian word RAM with byte/halfword/word loads and stores.
// Latency: loads and word stores done 1 cycle after acceptance, sub-word stores 2 (read-modify-write).
// Backpressure: ready_out only in IDLE; requests seen while busy are dropped, not queued.
// Ports: clk, reset (async active-low), bus (memory_ram_if.slave: request, data, ready/done/error).
module memory_ram #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 64
) (
    input logic         clk,
    input logic         reset,
    memory_ram_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic [2:0]           state;
    logic [AW+1:0]        addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] old_q;
    logic [1:0]           size_q;
    logic                 sign_q;
    logic [BIT_WIDTH-1:0] rdata_q;
    logic                 done_q;
    logic                 error_q;

    // Address bits above the array index are intentionally ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Address_in[BIT_WIDTH-1:AW+2];

    logic illegal;
    always_comb begin
        illegal = 1'b0;
        case (bus.size_in)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = bus.Address_in[0];
            2'b10:   illegal = (bus.Address_in[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    logic [AW-1:0]        idx_q;
    logic [4:0]           shamt;
    logic [BIT_WIDTH-1:0] rd_word;
    logic [BIT_WIDTH-1:0] shifted;
    logic [BIT_WIDTH-1:0] load_val;
    logic [BIT_WIDTH-1:0] lane_mask;
    logic [BIT_WIDTH-1:0] merged;

    assign idx_q   = addr_q[AW+1:2];
    assign shamt   = {addr_q[1:0], 3'b000};
    assign rd_word = mem[idx_q];
    assign shifted = rd_word >> shamt;

    always_comb begin
        load_val = rd_word;
        case (size_q)
            2'b00:   load_val = {{(BIT_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{(BIT_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Lanes being replaced by a sub-word store; everything else comes from old_q.
    always_comb begin
        lane_mask = {{(BIT_WIDTH-16){1'b0}}, 16'hFFFF};
        if (size_q == 2'b00) begin
            lane_mask = {{(BIT_WIDTH-8){1'b0}}, 8'hFF};
        end
        merged = (old_q & ~(lane_mask << shamt)) | ((wdata_q << shamt) & (lane_mask << shamt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_in) begin
                        if (illegal) begin
                            error_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.Address_in[AW+1:0];
                            wdata_q <= bus.Write_Data_in;
                            size_q  <= bus.size_in;
                            sign_q  <= bus.sign_in;
                            if (!bus.we_in) begin
                                state <= RD;
                            end else if (bus.size_in == 2'b10) begin
                                state <= WR;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                RD: begin
                    rdata_q <= load_val;
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                WR: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                RMW_RD: begin
                    old_q <= rd_word;
                    state <= RMW_WR;
                end
                RMW_WR: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; reset drops state to IDLE asynchronously, so an
    // abandoned access never reaches a write state.
    always_ff @(posedge clk) begin
        if (reset && state == WR) begin
            mem[idx_q] <= wdata_q;
        end else if (reset && state == RMW_WR) begin
            mem[idx_q] <= merged;
        end
    end

    assign bus.Read_Data_out = rdata_q;
    assign bus.ready_out     = (state == IDLE);
    assign bus.done_out      = done_q;
    assign bus.error_out     = error_q;
endmodule

// File: tb/tb_memory_ram.sv
// Directed bench for memory_ram: vector table of single accesses plus
// hand-written back-to-back, busy-drop and reset-abort sequences.
// Latency: n/a. Backpressure: accesses launched only from IDLE.
module tb_memory_ram;
    logic clk;
    logic reset;

    memory_ram_if #(.BIT_WIDTH(32)) bus ();

    memory_ram #(.BIT_WIDTH(32), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;    // 0 = rejected (error pulse), else cycles to done
        logic [31:0] rdata;  // Read_Data_out expected after completion
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v, input int id);
        int k;
        logic got_err;
        @(negedge clk);
        bus.req_in        = 1'b1;
        bus.we_in         = v.we;
        bus.size_in       = v.size;
        bus.sign_in       = v.sign;
        bus.Address_in    = v.addr;
        bus.Write_Data_in = v.wdata;
        @(posedge clk);
        #1;
        bus.req_in = 1'b0;
        k = 0;
        while (!bus.done_out && !bus.error_out && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        got_err = bus.error_out;
        if (k >= 8) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d timeout: no done/error within 8 cycles", id);
        end else begin
            check($sformatf("v%0d latency", id), k, v.lat);
            check($sformatf("v%0d error", id), {31'b0, got_err}, {31'b0, (v.lat == 0)});
        end
        check($sformatf("v%0d rdata", id), bus.Read_Data_out, v.rdata);
        check($sformatf("v%0d ready", id), {31'b0, bus.ready_out}, 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("v%0d pulse_end", id), {30'b0, bus.done_out, bus.error_out}, 32'd0);
    endtask

    vec_t vecs [21];
    vec_t v;
    logic saw_done;

    initial begin
        //          we    size   sign  addr          wdata          lat rdata
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hAAAAAA55, 2, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 32'hDEAD55EF};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        1, 32'hFFFFFFDE};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        1, 32'h000000DE};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1, 32'hFFFFDEAD};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        0, 32'hFFFFDEAD};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h12345678, 0, 32'hFFFFDEAD};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        0, 32'hFFFFDEAD};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 32'hDEAD55EF};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        1, 32'h00000055};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        1, 32'h000055EF};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234CAFE, 2, 32'h000055EF};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1, 32'hCAFE55EF};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,        1, 32'hFFFFFFEF};
        vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0BADF00D, 1, 32'hFFFFFFEF};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1, 32'h0BADF00D};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 32'h0000_0202, 32'h0,        1, 32'h000000AD};
        vecs[19] = '{1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h00000080, 2, 32'h000000AD};
        vecs[20] = '{1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,        1, 32'hFFFFFF80};

        bus.req_in        = 1'b0;
        bus.we_in         = 1'b0;
        bus.size_in       = 2'b00;
        bus.sign_in       = 1'b0;
        bus.Address_in    = '0;
        bus.Write_Data_in = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #20;
        check("reset ready", {31'b0, bus.ready_out}, 32'd1);
        check("reset done",  {31'b0, bus.done_out},  32'd0);
        check("reset error", {31'b0, bus.error_out}, 32'd0);
        check("reset rdata", bus.Read_Data_out,      32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_access(vecs[i], i);
        end

        // Request held high across a store: inputs changed while busy are
        // ignored, the follow-up load is taken as soon as ready returns and
        // sees the freshly written word.
        @(negedge clk);
        bus.req_in = 1'b1; bus.we_in = 1'b1; bus.size_in = 2'b10; bus.sign_in = 1'b0;
        bus.Address_in = 32'h20; bus.Write_Data_in = 32'h11223344;
        @(posedge clk); #1;
        bus.we_in = 1'b0; bus.Write_Data_in = 32'hFFFFFFFF;
        check("b2b busy ready", {31'b0, bus.ready_out}, 32'd0);
        @(posedge clk); #1;
        check("b2b store done", {31'b0, bus.done_out}, 32'd1);
        check("b2b ready back", {31'b0, bus.ready_out}, 32'd1);
        @(posedge clk); #1;
        bus.req_in = 1'b0;
        check("b2b load taken", {31'b0, bus.ready_out}, 32'd0);
        @(posedge clk); #1;
        check("b2b load done", {31'b0, bus.done_out}, 32'd1);
        check("b2b load data", bus.Read_Data_out, 32'h11223344);

        // One-cycle request while busy must be dropped, not queued.
        @(negedge clk);
        bus.req_in = 1'b1; bus.we_in = 1'b1; bus.size_in = 2'b00;
        bus.Address_in = 32'h20; bus.Write_Data_in = 32'h00000077;
        @(posedge clk); #1;
        bus.we_in = 1'b0; bus.size_in = 2'b10;
        @(posedge clk); #1;
        bus.req_in = 1'b0;
        @(posedge clk); #1;
        check("drop store done", {31'b0, bus.done_out}, 32'd1);
        @(posedge clk); #1;
        check("drop idle ready", {31'b0, bus.ready_out}, 32'd1);
        check("drop no done", {31'b0, bus.done_out}, 32'd0);
        check("drop rdata", bus.Read_Data_out, 32'h11223344);
        v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 32'h11223377};
        do_access(v, 100);

        // Reset asserted during RMW_RD of a byte store: abandoned, no write.
        @(negedge clk);
        bus.req_in = 1'b1; bus.we_in = 1'b1; bus.size_in = 2'b00;
        bus.Address_in = 32'h10; bus.Write_Data_in = 32'h00000099;
        @(posedge clk); #1;
        bus.req_in = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst ready", {31'b0, bus.ready_out}, 32'd1);
        check("rst done",  {31'b0, bus.done_out},  32'd0);
        check("rst error", {31'b0, bus.error_out}, 32'd0);
        check("rst rdata", bus.Read_Data_out,      32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            saw_done = saw_done | bus.done_out;
        end
        check("rst no done", {31'b0, saw_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        v = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hCAFE55EF};
        do_access(v, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
